pio_key_irq_ctrl: RTL

//  Parametrised Avalon-MM input PIO for push-buttons/switches: WIDTH channels, in_port synchroniser,

---
 rtl/pio_key_irq_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/pio_key_irq_ctrl.sv
// pio_key_irq_ctrl: Avalon-MM input PIO for keys/switches.
// WIDTH channels pass through a SYNC_STAGES synchroniser, then an optional
// per-channel debounce (compiled in when PIO_KEY_DEBOUNCE_EN is defined),
// then per-bit rise/fall edge capture and per-bit level/edge interrupt.
// Offsets 0/2/3 keep the layout of the original 4-bit key PIO.
module pio_key_irq_ctrl #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CNT_W    = 16,
  parameter int DB_RESET    = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic             wr_en;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] sync_w;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] irq_mode_q, irq_mode_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             unused_wd;

  assign wr_en     = chipselect && !write_n;
  assign sync_w    = sync_q[SYNC_STAGES-1];
  assign unused_wd = ^writedata;

  // Synchroniser shift chain: stage 0 samples the raw pins.
  always_comb begin
    sync_d[0] = in_port;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  // Synchroniser flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
    end
  end

`ifdef PIO_KEY_DEBOUNCE_EN
  logic [DB_CNT_W-1:0] db_limit_q, db_limit_d;
  logic [DB_CNT_W-1:0] cnt_q [WIDTH];
  logic [DB_CNT_W-1:0] cnt_d [WIDTH];
  logic [DB_CNT_W-1:0] leff_m1;

  // A limit of 0 behaves like 1; compare with >= so a lowered limit fires at once.
  assign leff_m1 = (db_limit_q == '0) ? '0 : db_limit_q - 1'b1;

  // Debounce: stable follows sync after Leff consecutive differing cycles.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync_w[i] != stable_q[i]) begin
        if (cnt_q[i] >= leff_m1) begin
          stable_d[i] = sync_w[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Debounce counters and limit register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_limit_q <= DB_CNT_W'(DB_RESET);
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      db_limit_q <= db_limit_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Debounce limit write.
  always_comb begin
    db_limit_d = db_limit_q;
    if (wr_en && address == 3'd6) begin
      db_limit_d = writedata[DB_CNT_W-1:0];
    end
  end
`else
  localparam int unused_db_cfg = DB_CNT_W + DB_RESET;

  // Without debounce the synchroniser output is taken every cycle.
  always_comb begin
    stable_d = sync_w;
  end
`endif

  // Control register writes and edge capture (a new edge beats a same-cycle clear).
  always_comb begin
    rise_en_d  = rise_en_q;
    irq_mask_d = irq_mask_q;
    fall_en_d  = fall_en_q;
    irq_mode_d = irq_mode_q;
    edge_cap_d = edge_cap_q;
    if (wr_en) begin
      case (address)
        3'd1:    rise_en_d  = writedata[WIDTH-1:0];
        3'd2:    irq_mask_d = writedata[WIDTH-1:0];
        3'd3:    edge_cap_d = edge_cap_q & ~writedata[WIDTH-1:0];
        3'd4:    fall_en_d  = writedata[WIDTH-1:0];
        3'd5:    irq_mode_d = writedata[WIDTH-1:0];
        default: ;
      endcase
    end
    edge_cap_d = edge_cap_d
               | (~stable_q &  stable_d & rise_en_q)
               | ( stable_q & ~stable_d & fall_en_q);
  end

  // Registered read mux, updated every cycle.
  always_comb begin
    readdata_d = '0;
    case (address)
      3'd0: readdata_d[WIDTH-1:0] = stable_q;
      3'd1: readdata_d[WIDTH-1:0] = rise_en_q;
      3'd2: readdata_d[WIDTH-1:0] = irq_mask_q;
      3'd3: readdata_d[WIDTH-1:0] = edge_cap_q;
      3'd4: readdata_d[WIDTH-1:0] = fall_en_q;
      3'd5: readdata_d[WIDTH-1:0] = irq_mode_q;
`ifdef PIO_KEY_DEBOUNCE_EN
      3'd6: readdata_d[DB_CNT_W-1:0] = db_limit_q;
`endif
      default: ;
    endcase
  end

  // Channel state, control registers and read data flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_q   <= '0;
      rise_en_q  <= '0;
      irq_mask_q <= '0;
      edge_cap_q <= '0;
      fall_en_q  <= '1;
      irq_mode_q <= '0;
      readdata_q <= '0;
    end else begin
      stable_q   <= stable_d;
      rise_en_q  <= rise_en_d;
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
      fall_en_q  <= fall_en_d;
      irq_mode_q <= irq_mode_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  // Built only from flop outputs, so no bus activity can glitch it.
  assign irq = |(irq_mask_q & ((irq_mode_q & edge_cap_q) | (~irq_mode_q & stable_q)));

endmodule
